// File: rtl/uart_frame_rx_if.sv
// Signal bundle between the UART frame receiver and its consumer.
// master: the receiver (reads the serial line, drives the results).
// slave:  the consumer / line driver.
interface uart_frame_rx_if;
   logic        uart_rx;
   logic [7:0]  byte_data;
   logic        byte_valid;
   logic [23:0] data_out;
   logic        data_valid;
   logic        frame_err;

   modport master (
      input  uart_rx,
      output byte_data, byte_valid, data_out, data_valid, frame_err
   );

   modport slave (
      output uart_rx,
      input  byte_data, byte_valid, data_out, data_valid, frame_err
   );
endinterface

// File: rtl/uart_frame_rx.sv
// 8N1 UART receiver plus frame parser for 24-bit sensor readings.
// Frame: HEADER, byte0, byte1, byte2, checksum (byte0+byte1+byte2 mod 256).
//
// Byte receiver states
//   state   | meaning
//   B_IDLE  | line idle, waiting for a falling edge on rx_s
//   B_START | half a bit in, confirming the start bit is still low
//   B_DATA  | sampling 8 data bits at mid-bit, LSB first
//   B_STOP  | sampling the stop bit (1 = byte accepted, 0 = framing error)
//
// Frame parser states
//   state   | meaning
//   P_HDR   | discarding bytes until HEADER arrives
//   P_D0    | expecting reading byte 0 (MSB)
//   P_D1    | expecting reading byte 1
//   P_D2    | expecting reading byte 2 (LSB)
//   P_CHK   | expecting the checksum byte
module uart_frame_rx #(
   parameter int          CLK_FRE   = 50,
   parameter int          UART_RATE = 9600,
   parameter logic [7:0]  HEADER    = 8'hA5,
   parameter int          GAP_BYTES = 2
) (
   input  logic           clk,
   input  logic           rst,
   uart_frame_rx_if.master bus
);

   localparam int CYCLE   = CLK_FRE * 1_000_000 / UART_RATE;
   localparam int HALF    = CYCLE / 2;
   localparam int CNT_W   = ($clog2(CYCLE) > 13) ? $clog2(CYCLE) : 13;
   localparam int GAP_LIM = GAP_BYTES * 10 * CYCLE;
   localparam int GAP_W   = $clog2(GAP_LIM + 1);

   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CYC_M1  = CNT_W'(CYCLE - 1);

   typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} b_state_t;
   typedef enum logic [2:0] {P_HDR, P_D0, P_D1, P_D2, P_CHK} p_state_t;

   b_state_t         b_state, b_next;
   p_state_t         p_state, p_next;

   logic [1:0]       rx_sync;
   logic             rx_s, rx_prev;
   logic [CNT_W-1:0] cnt;
   logic             cnt_zero;
   logic [2:0]       bit_idx;
   logic [7:0]       shift_q;
   logic             shift_en, stop_ok, stop_err;

   logic [7:0]       byte_q;
   logic             bv_q;
   logic [7:0]       sum;
   logic [23:0]      payload;
   logic [GAP_W-1:0] gap;
   logic             timeout;
   logic             store_en, chk_ok, chk_bad;
   logic [23:0]      data_q;
   logic             dv_q, ferr_q;

   assign rx_s     = rx_sync[1];
   assign cnt_zero = (cnt == '0);

   // Two-flop synchroniser and previous-sample register for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_sync <= 2'b11;
         rx_prev <= 1'b1;
      end else begin
         rx_sync <= {rx_sync[0], bus.uart_rx};
         rx_prev <= rx_s;
      end
   end

   // Byte receiver state register
   always_ff @(posedge clk) begin
      if (rst) b_state <= B_IDLE;
      else     b_state <= b_next;
   end

   // Byte receiver next-state logic
   always_comb begin
      b_next = b_state;
      case (b_state)
         B_IDLE:  if (rx_prev && !rx_s)           b_next = B_START;
         B_START: if (cnt_zero)                   b_next = rx_s ? B_IDLE : B_DATA;
         B_DATA:  if (cnt_zero && bit_idx == 3'd7) b_next = B_STOP;
         B_STOP:  if (cnt_zero)                   b_next = B_IDLE;
         default:                                 b_next = B_IDLE;
      endcase
   end

   // Byte receiver sample strobes
   always_comb begin
      shift_en = (b_state == B_DATA) && cnt_zero;
      stop_ok  = (b_state == B_STOP) && cnt_zero && rx_s;
      stop_err = (b_state == B_STOP) && cnt_zero && !rx_s;
   end

   // Bit timer (down-counter, reloaded on terminal count), bit index and shifter
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         bit_idx <= 3'd0;
         shift_q <= 8'h00;
      end else begin
         if (b_state == B_IDLE) cnt <= HALF_M1;
         else if (cnt_zero)     cnt <= CYC_M1;
         else                   cnt <= cnt - CNT_W'(1);

         if (b_state != B_DATA) bit_idx <= 3'd0;
         else if (shift_en)     bit_idx <= bit_idx + 3'd1;

         if (shift_en) shift_q <= {rx_s, shift_q[7:1]};
      end
   end

   // Accepted-byte strobe and data, one cycle after the stop-bit sample
   always_ff @(posedge clk) begin
      if (rst) begin
         bv_q   <= 1'b0;
         byte_q <= 8'h00;
      end else begin
         bv_q <= stop_ok;
         if (stop_ok) byte_q <= shift_q;
      end
   end

   // A bv_q cycle restarts the gap, so it can never coincide with a timeout
   assign timeout = (p_state != P_HDR) && !bv_q && (gap == '0);

   // Frame parser state register
   always_ff @(posedge clk) begin
      if (rst) p_state <= P_HDR;
      else     p_state <= p_next;
   end

   // Frame parser next-state logic; errors always resync to the header
   always_comb begin
      p_next = p_state;
      if (stop_err || timeout) begin
         p_next = P_HDR;
      end else if (bv_q) begin
         case (p_state)
            P_HDR:   if (byte_q == HEADER) p_next = P_D0;
            P_D0:    p_next = P_D1;
            P_D1:    p_next = P_D2;
            P_D2:    p_next = P_CHK;
            default: p_next = P_HDR;
         endcase
      end
   end

   // Frame parser per-byte actions
   always_comb begin
      store_en = bv_q && ((p_state == P_D0) || (p_state == P_D1) || (p_state == P_D2));
      chk_ok   = bv_q && (p_state == P_CHK) && (byte_q == sum);
      chk_bad  = bv_q && (p_state == P_CHK) && (byte_q != sum);
   end

   // Payload, checksum accumulator, inter-byte gap timer and result strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         sum     <= 8'h00;
         payload <= 24'h0;
         gap     <= '0;
         data_q  <= 24'h0;
         dv_q    <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         if (p_state == P_HDR) sum <= 8'h00;
         else if (store_en)    sum <= sum + byte_q;

         if (store_en) payload <= {payload[15:0], byte_q};

         if (p_next == P_HDR)  gap <= '0;
         else if (bv_q)        gap <= GAP_W'(GAP_LIM);
         else if (gap != '0)   gap <= gap - GAP_W'(1);

         dv_q   <= chk_ok && !stop_err;
         if (chk_ok && !stop_err) data_q <= payload;
         ferr_q <= stop_err || timeout || chk_bad;
      end
   end

   assign bus.byte_data  = byte_q;
   assign bus.byte_valid = bv_q;
   assign bus.data_out   = data_q;
   assign bus.data_valid = dv_q;
   assign bus.frame_err  = ferr_q;

endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Receive-side counterpart of the sensor report link: deserialises the UART stream that carries 24-bit DHT11 readings and recovers the reading on the host/peer side of the design. It combines an 8N1 byte receiver with a frame parser (header, three data bytes, checksum). Validated readings go to downstream logic (display, threshold compare) with a one-cycle strobe. Bad frames are flagged.

## Interface
- CLK_FRE, 50, system clock frequency in MHz
- UART_RATE, 9600, baud rate in bit/s
- HEADER, 8'hA5, frame start byte
- GAP_BYTES, 2, maximum idle gap between bytes of one frame, in byte times (10 bit times each)

- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- uart_rx  input  1  serial line, idle high, asynchronous to clk
- byte_data  output  8  last received byte
- byte_valid  output  1  one-cycle strobe, byte_data updated
- data_out  output  24  last good reading {byte0, byte1, byte2}, MSB byte first
- data_valid  output  1  one-cycle strobe, data_out updated
- frame_err  output  1  one-cycle strobe: stop-bit error, checksum mismatch or inter-byte timeout

## Operation
- CYCLE = CLK_FRE*1_000_000/UART_RATE (integer division); HALF = CYCLE/2. With defaults: CYCLE = 5208, HALF = 2604.
- uart_rx passes through a 2-flop synchroniser. Both flops reset to 1. All logic uses the synchronised value rx_s.
- Byte receiver FSM, states IDLE, START, DATA, STOP. It has a bit counter cnt (13 bits minimum) and a bit index 0..7.
  - IDLE: a falling edge of rx_s (previous 1, current 0) -> START, cnt = 0.
  - START: at cnt = HALF-1, if rx_s = 0 -> DATA with cnt = 0; if rx_s = 1 -> IDLE (glitch rejected, no strobe).
  - DATA: at cnt = CYCLE-1, sample rx_s into shift register, LSB first, cnt = 0. After the 8th sample -> STOP.
  - STOP: at cnt = CYCLE-1, sample rx_s. If 1 -> byte accepted. If 0 -> framing error. Either way -> IDLE. Back-to-back bytes (no idle bits) must be received.
- Frame parser FSM, states WAIT_HDR, D0, D1, D2, CHK. It advances only on accepted bytes.
  - WAIT_HDR: byte == HEADER -> D0. Any other byte is discarded silently.
  - D0/D1/D2: store the byte, add it to an 8-bit running sum (mod 256), advance. A byte equal to HEADER is treated as data.
  - CHK: byte == sum -> data_out loaded, data_valid pulsed. Byte != sum -> frame_err, data_out unchanged. Either way -> WAIT_HDR.
- Framing error on any byte: frame_err pulses, parser -> WAIT_HDR, byte_valid is not asserted.
- Inter-byte timeout: in D0..CHK, the gap counter counts cycles since the last accepted byte. If it reaches GAP_BYTES*10*CYCLE -> frame_err, parser -> WAIT_HDR. The gap counter is held at 0 in WAIT_HDR.
- If a framing error and a timeout fall on the same cycle, frame_err is a single one-cycle pulse.

## Timing
- Reset values: byte_data = 0, byte_valid = 0, data_out = 0, data_valid = 0, frame_err = 0. Both FSMs return to IDLE / WAIT_HDR and all counters clear. Reset mid-byte or mid-frame discards partial data with no strobe.
- Sample point: data bits are sampled at mid-bit, HALF + k*CYCLE cycles after the detected start edge. Detection adds 2 cycles of synchroniser delay.
- byte_valid and byte_data update on the cycle after the stop-bit sample.
- data_valid follows the checksum byte's byte_valid by exactly 1 cycle. data_out changes on that same cycle and is then held.
- frame_err (stop-bit error) comes on the cycle after the stop-bit sample. frame_err (checksum) comes 1 cycle after byte_valid. frame_err (timeout) comes 1 cycle after the threshold count.
- Strobes are never longer than one cycle. data_valid and frame_err are mutually exclusive in any cycle.

## Test plan
- Reset, then drive 8N1 frame A5 12 34 56 9C at 9600 baud (bit = 104160 ns) -> 5 byte_valid pulses; one data_valid; data_out = 24'h123456; no frame_err.
- Same frame with checksum 9D -> frame_err pulse 1 cycle after the 5th byte_valid; data_out stays at its previous value; next good frame A5 00 00 01 01 -> data_out = 24'h000001.
- Leading garbage 00 FF, then a good frame -> garbage bytes strobe byte_valid only; exactly one data_valid.
- Byte with stop bit = 0 inside a frame -> frame_err; no byte_valid for it; parser resyncs on the next A5.
- A5 12, then line idle > 20 byte times -> one frame_err at the timeout; a following good frame decodes correctly.
- Low glitch of 1000 ns on an idle line -> no strobes. Assert rst mid-byte -> all outputs 0; the next frame decodes correctly.
